// File: rtl/regfile_mp_pkg.sv
// Shared types for the multi-port register file: register index, data word
// and the busy-vector type driven by the pending-write scoreboard.
package regfile_mp_pkg;

  localparam int XLEN    = 32;
  localparam int RF_NREG = 32;
  localparam int RF_AW   = $clog2(RF_NREG);

  typedef logic [RF_AW-1:0]   reg_ind_t;
  typedef logic [XLEN-1:0]    data_t;
  typedef logic [RF_NREG-1:0] rf_busy_t;

  function automatic logic is_x0(reg_ind_t a);
    return a == '0;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports,
// destination allocation and flush, plus the busy outputs.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int NREAD  = 3,
  parameter int NWRITE = 2
) ();

  reg_ind_t            read_addr [NREAD];
  data_t               read_data [NREAD];
  logic [NREAD-1:0]    read_busy;

  logic [NWRITE-1:0]   we;
  reg_ind_t            write_addr [NWRITE];
  data_t               write_data [NWRITE];
  logic [NWRITE-1:0]   write_release;

  logic                alloc_valid;
  reg_ind_t            alloc_addr;
  logic                flush;
  rf_busy_t            busy_vec;

  modport master (
    output read_addr, we, write_addr, write_data, write_release,
           alloc_valid, alloc_addr, flush,
    input  read_data, read_busy, busy_vec
  );

  modport slave (
    input  read_addr, we, write_addr, write_data, write_release,
           alloc_valid, alloc_addr, flush,
    output read_data, read_busy, busy_vec
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, with flush over
// alloc over release priority. Bit 0 (x0) is never busy.
module rf_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NWRITE = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_alloc_valid,
  input  reg_ind_t          i_alloc_addr,
  input  logic [NWRITE-1:0] i_we,
  input  logic [NWRITE-1:0] i_write_release,
  input  reg_ind_t          i_write_addr [NWRITE],
  output rf_busy_t          o_busy_vec
);

  rf_busy_t r_busy;
  rf_busy_t w_release_hit;
  rf_busy_t w_busy_next;

  always_comb begin
    w_release_hit = '0;
    for (int k = 0; k < NWRITE; k++) begin
      if (i_we[k] && i_write_release[k]) begin
        w_release_hit[i_write_addr[k]] = 1'b1;
      end
    end
  end

  // A new producer supersedes a retiring one, so alloc outranks release.
  always_comb begin
    w_busy_next = r_busy;
    for (int r = 0; r < RF_NREG; r++) begin
      if (i_flush) begin
        w_busy_next[r] = 1'b0;
      end else if (i_alloc_valid && i_alloc_addr == reg_ind_t'(r)) begin
        w_busy_next[r] = 1'b1;
      end else if (w_release_hit[r]) begin
        w_busy_next[r] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NWRITE write ports (higher index wins),
// NREAD combinational read ports with optional write bypass, busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int NREAD  = 3,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  data_t            r_regs [RF_NREG];
  data_t            w_rd_data [NREAD];
  logic [NREAD-1:0] w_rd_busy;
  rf_busy_t         w_busy_vec;

  // Later ports are scanned last, so their non-blocking update wins a same-address conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < RF_NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < RF_NREG; r++) begin
        for (int k = 0; k < NWRITE; k++) begin
          if (bus.we[k] && bus.write_addr[k] == reg_ind_t'(r)) begin
            r_regs[r] <= bus.write_data[k];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      w_rd_data[i] = '0;
      w_rd_busy[i] = 1'b0;
      if (!is_x0(bus.read_addr[i])) begin
        w_rd_data[i] = r_regs[bus.read_addr[i]];
        w_rd_busy[i] = w_busy_vec[bus.read_addr[i]];
        // A releasing write already delivers the data, so the reader need not stall.
        if (BYPASS != 0) begin
          for (int k = 0; k < NWRITE; k++) begin
            if (bus.we[k] && bus.write_addr[k] == bus.read_addr[i]) begin
              w_rd_data[i] = bus.write_data[k];
              if (bus.write_release[k]) begin
                w_rd_busy[i] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .i_clk           (clk),
    .i_rst_n         (rst),
    .i_flush         (bus.flush),
    .i_alloc_valid   (bus.alloc_valid),
    .i_alloc_addr    (bus.alloc_addr),
    .i_we            (bus.we),
    .i_write_release (bus.write_release),
    .i_write_addr    (bus.write_addr),
    .o_busy_vec      (w_busy_vec)
  );

  assign bus.read_data = w_rd_data;
  assign bus.read_busy = w_rd_busy;
  assign bus.busy_vec  = w_busy_vec;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard, the successor of the single-write, two-read register file in the core datapath. It gives the decode stage `NREAD` combinational read ports and the writeback stage `NWRITE` write ports. Optional same-cycle write-to-read bypass is available. A per-register busy bit is set when decode allocates a destination register and cleared when writeback releases it, so hazard logic can stall on in-flight results. `x0` always reads zero and is never busy.

## Interface
Parameters:
- `NREAD`, default 3: number of read ports (1..4).
- `NWRITE`, default 2: number of write ports (1..2).
- `BYPASS`, default 1: 1 means a read returns same-cycle write data; 0 means a read returns stored data only.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset, asynchronous and active-low.
- `read_addr[NREAD]`  in  `reg_ind_t` each  — read addresses.
- `read_data[NREAD]`  out  `data_t` each  — read data (combinational).
- `read_busy[NREAD]`  out  1 each  — addressed register has an outstanding producer.
- `we[NWRITE]`  in  1 each  — write enable.
- `write_addr[NWRITE]`  in  `reg_ind_t` each  — write address.
- `write_data[NWRITE]`  in  `data_t` each  — write data.
- `write_release[NWRITE]`  in  1 each  — clear the busy bit of `write_addr` (qualified by `we`).
- `alloc_valid`  in  1  — decode claims destination `alloc_addr`.
- `alloc_addr`  in  `reg_ind_t`  — destination being claimed.
- `flush`  in  1  — synchronous clear of all busy bits (pipeline squash).
- `busy_vec`  out  32  — registered busy bits; bit 0 is always 0.

## Operation
- Storage holds `x1`..`x31`, each `data_t`. Address 0 always reads 0. Writes to address 0 are dropped. A release targeting `x0` is a no-op.
- Write: on a rising edge with `we[k]`=1, `reg[write_addr[k]]` takes the value of `write_data[k]`.
- Two writes to the same address in one cycle: the higher port index wins, for both storage and bypass.
- Read: `read_data[i]` = 0 if `read_addr[i]`=0. Otherwise, if `BYPASS`=1 and any `we[k]` hits `read_addr[i]`, it is the winning `write_data`. Otherwise it is the stored value.
- Busy next-state, evaluated per register `r`≠0 in this priority order:
  - `flush`=1: busy[r] becomes 0. This overrides alloc in the same cycle.
  - Else `alloc_valid` with `alloc_addr`=r: busy[r] becomes 1. Alloc beats a release on the same register in the same cycle, because the new producer supersedes the old one.
  - Else any `we[k]&write_release[k]` with `write_addr[k]`=r: busy[r] becomes 0.
  - Else busy[r] holds.
- `read_busy[i]` = busy[`read_addr[i]`]. If `BYPASS`=1 and a releasing write hits that address this cycle, `read_busy[i]`=0, because the data is already on `read_data[i]`. A same-cycle alloc is not visible until the next cycle.
- A write with `write_release`=0 updates data and leaves busy unchanged (for multi-write producers).

## Timing
- Reset (`rst`=0, asynchronous): all registers become 0 and all busy bits become 0, so `busy_vec`=0 and every `read_data`=0.
- Reset is removed synchronously to `clk` by the upstream reset synchroniser.
- Reset mid-operation: the in-flight write on that edge is lost, as are pending busy bits.
- Reads have zero latency.
- A write is visible at the storage output one cycle after its edge, and in the same cycle through the bypass.
- Busy set and clear take effect on the edge after the request; `busy_vec` is driven directly from flops.
- No handshake: every request is accepted in its cycle. Hazard stall is the consumer's decision.

## Structure
- `CorePack` gains:
  - `localparam RF_NREG = 32`.
  - `typedef logic [RF_NREG-1:0] rf_busy_t` for `busy_vec`.
  - Reuse of the existing `reg_ind_t` and `data_t`.
- Sub-module `rf_scoreboard` holds the busy flops: flush, alloc and release priority, and the `busy_vec` output.
- Data storage, write-port priority, and bypass muxing stay in `regfile_mp`.

## Test plan
- Reset then reads: assert `rst`=0 mid-run, read `x5`/`x31` → `read_data`=0, `busy_vec`=0 immediately, without waiting for a clock edge.
- Dual write conflict:
  - `we`=2'b11, both ports address `x7`, port0 writes `0x11`, port1 writes `0x22`.
  - Same-cycle read → `0x22` (BYPASS=1).
  - Next-cycle read → `0x22`.
- x0 immunity: write `0xDEAD` to `x0`, alloc `x0` → read 0, `busy_vec[0]`=0.
- Bypass off:
  - `BYPASS`=0, write `0x5A` to `x3` while reading `x3` (previously `0x01`).
  - Same cycle → `0x01`; next cycle → `0x5A`.
- Scoreboard race:
  - Alloc `x9`, then next cycle `busy_vec[9]`=1.
  - Release `x9` and alloc `x9` in the same cycle → remains 1.
  - Release alone → 0 next cycle.
  - A releasing write on `x9` → `read_busy`=0 in the same cycle.
- Flush: busy `x2`,`x4`,`x6` set, `flush`=1 together with alloc `x8` → `busy_vec`=0 next cycle.
